debug_loader: RTL and testbench

- Write-side counterpart of the core's debug inspection port (select/derreference/word).
- Accepts host write requests for instruction memory, register file or data memory, and holds the pipeline while it writes.
- Performs the write, then reads the location back through the inspection port and reports match/mismatch to the host.
- Sits beside the mips top; the readback path drives the existing infoChooser inputs.

---
 rtl/debug_loader_if.sv | 26 ++
 rtl/debug_loader.sv | 181 ++++++++++++++++++
 tb/tb_debug_loader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_loader_if.sv
// Host-side request/response channel of the debug loader.
// Carries write requests in, verify results out, and the hold-release pulse.
interface debug_loader_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_select;
    logic [9:0]  req_address;
    logic [31:0] req_data;
    logic        hold_release;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_ok;
    logic [31:0] rsp_word;

    modport master (
        output req_valid, req_select, req_address, req_data,
        output hold_release, rsp_ready,
        input  req_ready, rsp_valid, rsp_ok, rsp_word
    );

    modport slave (
        input  req_valid, req_select, req_address, req_data,
        input  hold_release, rsp_ready,
        output req_ready, rsp_valid, rsp_ok, rsp_word
    );
endinterface

// File: rtl/debug_loader.sv
// Debug write loader: freezes the core, writes imem/regs/dmem,
// then reads the location back through the inspection port.
module debug_loader #(
    parameter int DRAIN_CYCLES = 5,
    parameter int READ_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    debug_loader_if.slave host,
    output logic          cpu_hold,
    output logic          imem_we,
    output logic          reg_we,
    output logic          dmem_we,
    output logic [9:0]    wr_address,
    output logic [31:0]   wr_data,
    output logic [1:0]    select,
    output logic [9:0]    derreference,
    input  logic [31:0]   word
);
    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        CHECK,
        WRITE,
        VERIFY,
        RESP
    } state_t;

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
    localparam logic [7:0] READ_LAST  = 8'(READ_LATENCY - 1);

    state_t      state;
    state_t      nextState;
    logic [7:0]  cnt;
    logic        holdFlag;
    logic        relPend;
    logic [1:0]  latSel;
    logic [9:0]  latAddr;
    logic [31:0] latData;
    logic        rspOk;
    logic [31:0] rspWord;
    logic        reject;
    logic        leaveResp;

    assign cpu_hold      = holdFlag;
    assign host.rsp_ok   = rspOk;
    assign host.rsp_word = rspWord;
    assign leaveResp     = (state == RESP) && host.rsp_ready;

    always_comb begin
        reject = 1'b0;
        unique case (latSel)
            2'b00:   reject = latAddr > 10'd255;
            2'b01:   reject = (latAddr > 10'd31) || (latAddr == 10'd0);
            2'b10:   reject = 1'b0;
            default: reject = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState      = state;
        host.req_ready = 1'b0;
        host.rsp_valid = 1'b0;
        imem_we        = 1'b0;
        reg_we         = 1'b0;
        dmem_we        = 1'b0;
        wr_address     = '0;
        wr_data        = '0;
        select         = '0;
        derreference   = '0;
        unique case (state)
            IDLE: begin
                host.req_ready = 1'b1;
                if (host.req_valid) begin
                    nextState = holdFlag ? CHECK : DRAIN;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    nextState = CHECK;
                end
            end
            CHECK: begin
                nextState = reject ? RESP : WRITE;
            end
            WRITE: begin
                wr_address = latAddr;
                wr_data    = latData;
                unique case (1'b1)
                    (latSel == 2'b00): imem_we = holdFlag;
                    (latSel == 2'b01): reg_we  = holdFlag;
                    (latSel == 2'b10): dmem_we = holdFlag;
                    default: ;
                endcase
                nextState = VERIFY;
            end
            VERIFY: begin
                select       = latSel;
                derreference = latAddr;
                if (cnt == READ_LAST) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                host.rsp_valid = 1'b1;
                if (host.rsp_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // One counter serves both the drain wait and the readback wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (nextState != state) begin
            cnt <= '0;
        end else if (state == DRAIN || state == VERIFY) begin
            cnt <= cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latSel  <= '0;
            latAddr <= '0;
            latData <= '0;
        end else if (state == IDLE && host.req_valid) begin
            latSel  <= host.req_select;
            latAddr <= host.req_address;
            latData <= host.req_data;
        end
    end

    // A request beats a simultaneous release; the release is deferred
    // until the response has been taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            holdFlag <= 1'b0;
            relPend  <= 1'b0;
        end else if (state == IDLE) begin
            if (host.req_valid) begin
                holdFlag <= 1'b1;
                relPend  <= host.hold_release;
            end else if (host.hold_release) begin
                holdFlag <= 1'b0;
                relPend  <= 1'b0;
            end
        end else if (leaveResp) begin
            if (relPend || host.hold_release) begin
                holdFlag <= 1'b0;
            end
            relPend <= 1'b0;
        end else if (host.hold_release) begin
            relPend <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rspOk   <= 1'b0;
            rspWord <= '0;
        end else if (state == CHECK && reject) begin
            rspOk   <= 1'b0;
            rspWord <= '0;
        end else if (state == VERIFY && cnt == READ_LAST) begin
            rspOk   <= (word == latData);
            rspWord <= word;
        end
    end
endmodule

// File: tb/tb_debug_loader.sv
// Scoreboard bench for debug_loader with a behavioural memory
// model standing in for the core behind the inspection port.
module tb_debug_loader;
    localparam int DRAIN = 5;
    localparam int RLAT  = 1;
    localparam int LIMIT = 40;

    typedef struct packed {
        logic        ok;
        logic [31:0] w;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        cpu_hold;
    logic        imem_we;
    logic        reg_we;
    logic        dmem_we;
    logic [9:0]  wr_address;
    logic [31:0] wr_data;
    logic [1:0]  select;
    logic [9:0]  derreference;
    logic [31:0] word;

    debug_loader_if hostIf ();

    debug_loader #(
        .DRAIN_CYCLES(DRAIN),
        .READ_LATENCY(RLAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .host        (hostIf.slave),
        .cpu_hold    (cpu_hold),
        .imem_we     (imem_we),
        .reg_we      (reg_we),
        .dmem_we     (dmem_we),
        .wr_address  (wr_address),
        .wr_data     (wr_data),
        .select      (select),
        .derreference(derreference),
        .word        (word)
    );

    int nTests = 0;
    int nFail  = 0;
    exp_t sbq[$];

    logic [31:0] imemM [256];
    logic [31:0] regM  [32];
    logic [31:0] dmemM [1024];
    logic        corrupt;
    logic [31:0] wordRaw;
    int imemCnt = 0;
    int regCnt  = 0;
    int dmemCnt = 0;
    logic holdWatch;
    logic holdLow;
    logic [9:0]  lastAddr;
    logic [31:0] lastData;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always_comb begin
        wordRaw = '0;
        case (select)
            2'b00:   wordRaw = imemM[derreference[7:0]];
            2'b01:   wordRaw = regM[derreference[4:0]];
            2'b10:   wordRaw = dmemM[derreference];
            default: wordRaw = '0;
        endcase
        word = wordRaw ^ {31'b0, corrupt};
    end

    always @(posedge clk) begin
        if (imem_we) begin
            imemM[wr_address[7:0]] <= wr_data;
            imemCnt <= imemCnt + 1;
        end
        if (reg_we) begin
            regM[wr_address[4:0]] <= wr_data;
            regCnt <= regCnt + 1;
        end
        if (dmem_we) begin
            dmemM[wr_address] <= wr_data;
            dmemCnt <= dmemCnt + 1;
        end
    end

    always @(negedge clk) begin
        if (holdWatch && !cpu_hold) holdLow <= 1'b1;
        if (!reset && hostIf.rsp_valid && hostIf.rsp_ready) begin
            if (sbq.size() == 0) begin
                chk("rspUnexpected", 32'(hostIf.rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rspOk", 32'(hostIf.rsp_ok), 32'(e.ok));
                chk("rspWord", hostIf.rsp_word, e.w);
            end
        end
    end

    function automatic logic isReject(input logic [1:0] s,
                                      input logic [9:0] a);
        return (s == 2'b11) || (s == 2'b00 && a > 10'd255)
            || (s == 2'b01 && (a > 10'd31 || a == 10'd0));
    endfunction

    function automatic int strobes();
        return imemCnt + regCnt + dmemCnt;
    endfunction

    task automatic doReq(input logic [1:0] sel, input logic [9:0] addr,
                         input logic [31:0] data, input logic rel,
                         output int edges, output int weEdge,
                         output logic holdAcc);
        int waitN;
        exp_t e;
        waitN = 0;
        while (!hostIf.req_ready && waitN < LIMIT) begin
            @(posedge clk); #1;
            waitN++;
        end
        hostIf.req_valid    = 1'b1;
        hostIf.req_select   = sel;
        hostIf.req_address  = addr;
        hostIf.req_data     = data;
        hostIf.hold_release = rel;
        if (isReject(sel, addr)) begin
            e.ok = 1'b0;
            e.w  = '0;
        end else begin
            e.ok = ~corrupt;
            e.w  = data ^ {31'b0, corrupt};
        end
        sbq.push_back(e);
        @(posedge clk); #1;
        hostIf.req_valid    = 1'b0;
        hostIf.hold_release = 1'b0;
        holdAcc = cpu_hold;
        edges   = 1;
        weEdge  = 0;
        while (!hostIf.rsp_valid && edges < LIMIT) begin
            if (imem_we || reg_we || dmem_we) begin
                weEdge   = edges;
                lastAddr = wr_address;
                lastData = wr_data;
            end
            @(posedge clk); #1;
            edges++;
        end
        chk("rspSeen", 32'(hostIf.rsp_valid), 32'd1);
    endtask

    initial begin
        int edges;
        int weEdge;
        int s0;
        int bad;
        logic holdAcc;
        logic [31:0] w0;
        logic o0;

        reset = 1'b1;
        corrupt = 1'b0;
        holdWatch = 1'b0;
        holdLow = 1'b0;
        hostIf.req_valid = 1'b0;
        hostIf.req_select = '0;
        hostIf.req_address = '0;
        hostIf.req_data = '0;
        hostIf.hold_release = 1'b0;
        hostIf.rsp_ready = 1'b1;
        #12;
        chk("rstReady", 32'(hostIf.req_ready), 32'd1);
        chk("rstHold", 32'(cpu_hold), 32'd0);
        chk("rstRspValid", 32'(hostIf.rsp_valid), 32'd0);
        chk("rstStrobes", 32'({imem_we, reg_we, dmem_we}), 32'd0);
        #10 reset = 1'b0;
        @(posedge clk); #1;

        // First request: full drain, dmem write
        s0 = strobes();
        doReq(2'b10, 10'h004, 32'hDEADBEEF, 1'b0, edges, weEdge, holdAcc);
        chk("t1HoldAtAccept", 32'(holdAcc), 32'd1);
        chk("t1Latency", 32'(edges), 32'(1 + DRAIN + 1 + 1 + RLAT));
        chk("t1WeEdge", 32'(weEdge), 32'(2 + DRAIN));
        chk("t1WrAddr", 32'(lastAddr), 32'h004);
        chk("t1WrData", lastData, 32'hDEADBEEF);
        chk("t1Strobes", 32'(strobes() - s0), 32'd1);
        chk("t1DmemCnt", 32'(dmemCnt), 32'd1);

        // Rejected requests while held
        s0 = strobes();
        doReq(2'b01, 10'd0, 32'h11111111, 1'b0, edges, weEdge, holdAcc);
        doReq(2'b11, 10'd3, 32'h22222222, 1'b0, edges, weEdge, holdAcc);
        chk("rejLatency", 32'(edges), 32'd2);
        doReq(2'b00, 10'd300, 32'h33333333, 1'b0, edges, weEdge, holdAcc);
        doReq(2'b01, 10'd32, 32'h44444444, 1'b0, edges, weEdge, holdAcc);
        @(posedge clk); #1;
        chk("rejStrobes", 32'(strobes() - s0), 32'd0);

        // Release while idle drops hold on the next edge
        chk("holdBeforeRel", 32'(cpu_hold), 32'd1);
        hostIf.hold_release = 1'b1;
        @(posedge clk); #1;
        hostIf.hold_release = 1'b0;
        chk("holdAfterRel", 32'(cpu_hold), 32'd0);

        // Back-to-back imem writes: only the first drains
        s0 = imemCnt;
        doReq(2'b00, 10'h010, 32'hA0000010, 1'b0, edges, weEdge, holdAcc);
        chk("b2bFirstLat", 32'(edges), 32'(1 + DRAIN + 1 + 1 + RLAT));
        holdWatch = 1'b1;
        doReq(2'b00, 10'h011, 32'hA0000011, 1'b0, edges, weEdge, holdAcc);
        chk("b2bSecondLat", 32'(edges), 32'(1 + 1 + 1 + RLAT));
        chk("b2bWeEdge", 32'(weEdge), 32'd2);
        @(posedge clk); #1;
        holdWatch = 1'b0;
        chk("b2bHoldStayed", 32'(holdLow), 32'd0);
        chk("b2bImemPulses", 32'(imemCnt - s0), 32'd2);

        // Readback corrupted in bit 0
        corrupt = 1'b1;
        doReq(2'b01, 10'd5, 32'h12345678, 1'b0, edges, weEdge, holdAcc);
        chk("corWrData", lastData, 32'h12345678);
        @(posedge clk); #1;
        corrupt = 1'b0;

        // Host stalls the response; release arrives meanwhile
        hostIf.rsp_ready = 1'b0;
        doReq(2'b10, 10'h007, 32'hA5A5F00D, 1'b0, edges, weEdge, holdAcc);
        w0 = hostIf.rsp_word;
        o0 = hostIf.rsp_ok;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            hostIf.hold_release = (i == 4);
            if (!hostIf.rsp_valid || hostIf.rsp_word != w0
                || hostIf.rsp_ok != o0 || hostIf.req_ready) bad++;
        end
        hostIf.hold_release = 1'b0;
        chk("stallStable", 32'(bad), 32'd0);
        chk("stallWord", w0, 32'hA5A5F00D);
        chk("holdInResp", 32'(cpu_hold), 32'd1);
        hostIf.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("idleAfterResp", 32'(hostIf.req_ready), 32'd1);
        @(posedge clk); #1;
        chk("holdAfterResp", 32'(cpu_hold), 32'd0);

        // Release together with a request: request wins
        doReq(2'b10, 10'h020, 32'hCAFE0020, 1'b1, edges, weEdge, holdAcc);
        chk("relReqHold", 32'(holdAcc), 32'd1);
        chk("relReqLat", 32'(edges), 32'(1 + DRAIN + 1 + 1 + RLAT));
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("relReqDropped", 32'(cpu_hold), 32'd0);

        // Reset during drain
        s0 = strobes();
        hostIf.req_valid   = 1'b1;
        hostIf.req_select  = 2'b10;
        hostIf.req_address = 10'h009;
        hostIf.req_data    = 32'h0BADF00D;
        @(posedge clk); #1;
        hostIf.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("drainHold", 32'(cpu_hold), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstMidHold", 32'(cpu_hold), 32'd0);
        chk("rstMidReady", 32'(hostIf.req_ready), 32'd1);
        #10 reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
        end
        chk("rstNoStrobes", 32'(strobes() - s0), 32'd0);
        chk("rstNoRsp", 32'(hostIf.rsp_valid), 32'd0);
        chk("sbDrained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
